// File: rtl/buster_shot_controller.sv
// rtl/buster_shot_controller.sv - buster projectile slot pool: spawn, cooldown, per-frame motion, retire
module buster_shot_controller #(
  parameter int NUM_SHOTS       = 3,
  parameter int SHOT_SPEED      = 4,
  parameter int SHOT_W          = 8,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MUZZLE_X        = 60,
  parameter int MUZZLE_Y        = 28,
  parameter int SCREEN_RIGHT    = 639
) (
  input  logic                    Clk,
  input  logic                    RESET,
  input  logic                    frame_clk,
  input  logic                    x_shoot_key,
  input  logic                    last_horizontal,
  input  logic [9:0]              Megaman_x_position,
  input  logic [9:0]              Megaman_y_position,
  input  logic [NUM_SHOTS-1:0]    shot_clear,
  output logic [NUM_SHOTS-1:0]    shot_active,
  output logic [NUM_SHOTS-1:0]    shot_dir,
  output logic [10*NUM_SHOTS-1:0] shot_x,
  output logic [10*NUM_SHOTS-1:0] shot_y,
  output logic                    shot_fired,
  output logic [3:0]              shots_in_flight
);

  localparam logic [10:0] LIMIT11 = 11'(SCREEN_RIGHT - SHOT_W);
  localparam logic [10:0] SPD11   = 11'(SHOT_SPEED);
  localparam logic [9:0]  SPD10   = 10'(SHOT_SPEED);
  localparam logic [10:0] MUZX11  = 11'(MUZZLE_X);
  localparam logic [10:0] W11     = 11'(SHOT_W);
  localparam logic [9:0]  MUZY10  = 10'(MUZZLE_Y);
  localparam logic [7:0]  CD8     = 8'(COOLDOWN_FRAMES);

  logic [NUM_SHOTS-1:0] active_q, active_d, dir_q, dir_d, sel;
  logic [9:0]           x_q [NUM_SHOTS];
  logic [9:0]           x_d [NUM_SHOTS];
  logic [9:0]           y_q [NUM_SHOTS];
  logic [9:0]           y_d [NUM_SHOTS];
  logic [7:0]           cd_q, cd_d;
  logic                 prev_q, prev_d, fd_q, tick_q, fired_q, fired_d;
  logic                 press, found, suppress, do_spawn;
  logic [10:0]          spawn_x11, mx11;
  logic [9:0]           spawn_y;

  assign mx11    = {1'b0, Megaman_x_position};
  assign spawn_y = Megaman_y_position + MUZY10;

  always_comb begin
    active_d  = active_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    cd_d      = cd_q;
    prev_d    = prev_q;
    fired_d   = 1'b0;
    press     = 1'b0;
    found     = 1'b0;
    sel       = '0;
    suppress  = 1'b0;
    do_spawn  = 1'b0;
    spawn_x11 = '0;
    if (tick_q) begin
      for (int n = 0; n < NUM_SHOTS; n++) begin
        if (active_q[n] && !shot_clear[n]) begin
          if (dir_q[n]) begin
            if (({1'b0, x_q[n]} + SPD11) > LIMIT11) active_d[n] = 1'b0;
            else                                    x_d[n] = x_q[n] + SPD10;
          end else begin
            if ({1'b0, x_q[n]} < SPD11) active_d[n] = 1'b0;
            else                        x_d[n] = x_q[n] - SPD10;
          end
        end
      end
      press  = x_shoot_key & ~prev_q;
      prev_d = x_shoot_key;
      // allocation looks at pre-tick flags so a slot freed this tick waits one frame
      for (int n = 0; n < NUM_SHOTS; n++) begin
        if (!active_q[n] && !found) begin
          found  = 1'b1;
          sel[n] = 1'b1;
        end
      end
      if (last_horizontal) begin
        spawn_x11 = mx11 + MUZX11;
        suppress  = spawn_x11 > LIMIT11;
      end else begin
        spawn_x11 = mx11 - W11;
        suppress  = mx11 < W11;
      end
      do_spawn = press && (cd_q == 8'd0) && found && !suppress;
      if (do_spawn) begin
        for (int n = 0; n < NUM_SHOTS; n++) begin
          if (sel[n]) begin
            active_d[n] = 1'b1;
            dir_d[n]    = last_horizontal;
            x_d[n]      = spawn_x11[9:0];
            y_d[n]      = spawn_y;
          end
        end
        fired_d = 1'b1;
        cd_d    = CD8;
      end else if (cd_q != 8'd0) begin
        cd_d = cd_q - 8'd1;
      end
    end
    active_d = active_d & ~shot_clear;
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      active_q <= '0;
      dir_q    <= '0;
      for (int n = 0; n < NUM_SHOTS; n++) begin
        x_q[n] <= '0;
        y_q[n] <= '0;
      end
      cd_q     <= '0;
      prev_q   <= 1'b0;
      fd_q     <= 1'b0;
      tick_q   <= 1'b0;
      fired_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cd_q     <= cd_d;
      prev_q   <= prev_d;
      fd_q     <= frame_clk;
      tick_q   <= frame_clk & ~fd_q;
      fired_q  <= fired_d;
    end
  end

  always_comb begin
    shots_in_flight = '0;
    for (int n = 0; n < NUM_SHOTS; n++) begin
      shots_in_flight = shots_in_flight + {3'b000, active_q[n]};
      shot_x[10*n +: 10] = x_q[n];
      shot_y[10*n +: 10] = y_q[n];
    end
  end

  assign shot_active = active_q;
  assign shot_dir    = dir_q;
  assign shot_fired  = fired_q;

endmodule

// File: tb/tb_buster_shot_controller.sv
// tb/tb_buster_shot_controller.sv - randomized bench for buster_shot_controller against a frame-level model
module tb_buster_shot_controller;
  localparam int NS = 3;

  logic          Clk = 1'b0;
  logic          RESET, frame_clk, x_shoot_key, last_horizontal;
  logic [9:0]    Megaman_x_position, Megaman_y_position;
  logic [NS-1:0] shot_clear, shot_active, shot_dir;
  logic [10*NS-1:0] shot_x, shot_y;
  logic          shot_fired;
  logic [3:0]    shots_in_flight;

  int tests = 0;
  int failed = 0;

  bit m_act [NS];
  bit m_dir [NS];
  int m_x [NS];
  int m_y [NS];
  int m_cd;
  bit m_prev, m_fd, m_tick, m_fired;

  buster_shot_controller dut (
    .Clk(Clk), .RESET(RESET), .frame_clk(frame_clk), .x_shoot_key(x_shoot_key),
    .last_horizontal(last_horizontal), .Megaman_x_position(Megaman_x_position),
    .Megaman_y_position(Megaman_y_position), .shot_clear(shot_clear),
    .shot_active(shot_active), .shot_dir(shot_dir), .shot_x(shot_x), .shot_y(shot_y),
    .shot_fired(shot_fired), .shots_in_flight(shots_in_flight)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit pre_act [NS];
    int free_slot, sx, mx;
    bit sup, press;
    if (RESET) begin
      for (int n = 0; n < NS; n++) begin
        m_act[n] = 0; m_dir[n] = 0; m_x[n] = 0; m_y[n] = 0;
      end
      m_cd = 0; m_prev = 0; m_fd = 0; m_tick = 0; m_fired = 0;
      return;
    end
    pre_act = m_act;
    free_slot = -1;
    mx = int'(Megaman_x_position);
    m_fired = 0;
    if (m_tick) begin
      for (int n = 0; n < NS; n++) begin
        if (pre_act[n] && !shot_clear[n]) begin
          if (m_dir[n]) begin
            if (m_x[n] + 4 > 631) m_act[n] = 0; else m_x[n] = m_x[n] + 4;
          end else begin
            if (m_x[n] < 4) m_act[n] = 0; else m_x[n] = m_x[n] - 4;
          end
        end
      end
      press = x_shoot_key && !m_prev;
      m_prev = x_shoot_key;
      for (int n = 0; n < NS; n++)
        if (!pre_act[n] && free_slot < 0) free_slot = n;
      if (last_horizontal) begin
        sx = mx + 60; sup = (sx > 631);
      end else begin
        sx = mx - 8;  sup = (mx < 8);
      end
      if (press && m_cd == 0 && free_slot >= 0 && !sup) begin
        m_act[free_slot] = 1;
        m_dir[free_slot] = last_horizontal;
        m_x[free_slot]   = sx;
        m_y[free_slot]   = (int'(Megaman_y_position) + 28) % 1024;
        m_fired = 1;
        m_cd = 8;
      end else if (m_cd > 0) begin
        m_cd--;
      end
    end
    for (int n = 0; n < NS; n++)
      if (shot_clear[n]) m_act[n] = 0;
    m_tick = frame_clk && !m_fd;
    m_fd = frame_clk;
  endtask

  task automatic compare();
    logic [NS-1:0] ea, ed;
    logic [10*NS-1:0] ex, ey;
    int cnt;
    cnt = 0;
    for (int n = 0; n < NS; n++) begin
      ea[n] = m_act[n];
      ed[n] = m_dir[n];
      ex[10*n +: 10] = 10'(m_x[n]);
      ey[10*n +: 10] = 10'(m_y[n]);
      cnt += int'(m_act[n]);
    end
    check("shot_active", 64'(shot_active), 64'(ea));
    check("shot_dir", 64'(shot_dir), 64'(ed));
    check("shot_x", 64'(shot_x), 64'(ex));
    check("shot_y", 64'(shot_y), 64'(ey));
    check("shot_fired", 64'(shot_fired), 64'(m_fired));
    check("shots_in_flight", 64'(shots_in_flight), 64'(cnt));
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic frame_tick();
    frame_clk = 1'b1; step();
    frame_clk = 1'b0; step();
  endtask

  initial begin
    RESET = 1'b1; frame_clk = 1'b0; x_shoot_key = 1'b0; last_horizontal = 1'b1;
    Megaman_x_position = 10'd100; Megaman_y_position = 10'd337; shot_clear = '0;
    step(); step();
    check("reset_active", 64'(shot_active), 64'd0);
    check("reset_fired", 64'(shot_fired), 64'd0);
    RESET = 1'b0;
    step();
    x_shoot_key = 1'b1;
    step();
    frame_tick();
    check("spawn_x", 64'(shot_x[9:0]), 64'd160);
    check("spawn_y", 64'(shot_y[9:0]), 64'd365);
    check("spawn_dir", 64'(shot_dir[0]), 64'd1);
    check("spawn_pulse", 64'(shot_fired), 64'd1);
    step();
    check("pulse_width", 64'(shot_fired), 64'd0);
    repeat (3) frame_tick();
    check("moved_x", 64'(shot_x[9:0]), 64'd172);
    check("held_one_shot", 64'(shots_in_flight), 64'd1);

    for (int c = 0; c < 15000; c++) begin
      frame_clk = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) x_shoot_key = ~x_shoot_key;
      if ($urandom_range(0, 15) == 0) last_horizontal = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0: Megaman_x_position = 10'($urandom_range(0, 15));
          1: Megaman_x_position = 10'($urandom_range(560, 620));
          2: Megaman_x_position = 10'($urandom_range(0, 1023));
          default: Megaman_x_position = 10'($urandom_range(90, 110));
        endcase
        Megaman_y_position = 10'($urandom_range(0, 1023));
      end
      shot_clear = ($urandom_range(0, 19) == 0) ? NS'($urandom_range(0, 7)) : '0;
      RESET = ($urandom_range(0, 599) == 0);
      step();
    end

    shot_clear = '0;
    RESET = 1'b1;
    step();
    check("final_reset_active", 64'(shot_active), 64'd0);
    check("final_reset_x", 64'(shot_x), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/buster_shot_controller.md
# buster_shot_controller

Schedules and sequences Megaman's buster projectiles. Owns a small pool of shot slots: it allocates a free slot when the shoot key is pressed, enforces a refire cooldown, and advances every live shot once per frame. It retires shots at the screen edges or on request from collision logic. It sits beside the Megaman movement FSM, consuming its position and facing outputs, and drives the sprite/colour mapper with per-slot shot positions.

## Interface

Parameters:
- NUM_SHOTS, 3, number of shot slots (1-8)
- SHOT_SPEED, 4, pixels moved per frame tick
- SHOT_W, 8, shot sprite width in pixels
- COOLDOWN_FRAMES, 8, frame ticks after a spawn before the next spawn is allowed
- MUZZLE_X, 60, x offset from Megaman_x_position for a right-facing spawn
- MUZZLE_Y, 28, y offset from Megaman_y_position for every spawn
- SCREEN_RIGHT, 639, rightmost visible pixel

Ports:
- Clk, in, 1, system clock; the only clock
- RESET, in, 1, synchronous, active-high reset
- frame_clk, in, 1, vertical-sync-rate strobe; rising edge detected internally
- x_shoot_key, in, 1, shoot key level
- last_horizontal, in, 1, facing: 1 = right, 0 = left
- Megaman_x_position, in, 10, Megaman sprite left x
- Megaman_y_position, in, 10, Megaman sprite top y
- shot_clear, in, NUM_SHOTS, per-slot retire request from collision logic (any cycle)
- shot_active, out, NUM_SHOTS, slot live flags
- shot_dir, out, NUM_SHOTS, per-slot direction: 1 = right
- shot_x, out, 10*NUM_SHOTS, slot n in bits [10n+9:10n]
- shot_y, out, 10*NUM_SHOTS, same packing
- shot_fired, out, 1, one-Clk pulse on every successful spawn
- shots_in_flight, out, 4, population count of shot_active

## Operation

- Frame tick: register frame_clk into frame_clk_delayed. tick is a register loaded with frame_clk & ~frame_clk_delayed. It is high for exactly one Clk per frame_clk rising edge.
- All slot state, shoot_prev and cooldown change only on tick, with one exception: shot_clear.
- shot_clear[n] high in any cycle: shot_active[n] is 0 the next cycle. It takes priority over movement in the same cycle. The other fields of slot n hold.
- On tick, in this order, all computed from pre-tick registered values:
  - Move: for each active, non-cleared slot:
    - Right: if x + SHOT_SPEED > SCREEN_RIGHT - SHOT_W (11-bit compare), deactivate; else x += SHOT_SPEED.
    - Left: if x < SHOT_SPEED, deactivate; else x -= SHOT_SPEED.
    - y never changes.
  - Press detect: press = x_shoot_key & ~shoot_prev. Then shoot_prev <= x_shoot_key. Holding the key fires once only.
  - Spawn: requires press, cooldown == 0, and at least one slot with pre-tick shot_active == 0. Choose the lowest-index such slot.
    - Right facing: x = Megaman_x + MUZZLE_X. Suppress if that value > SCREEN_RIGHT - SHOT_W (11-bit).
    - Left facing: x = Megaman_x - SHOT_W. Suppress if Megaman_x < SHOT_W.
    - y = Megaman_y + MUZZLE_Y, truncated to 10 bits.
    - dir = last_horizontal.
    - The spawned slot does not move on its spawn tick.
  - Cooldown:
    - Successful spawn: load COOLDOWN_FRAMES.
    - Otherwise: decrement, saturating at 0.
    - A suppressed or blocked spawn does not load cooldown.
- A slot retired on tick T, by movement or by clear, becomes allocatable on tick T+1, not on T.
- A press that is blocked (pool full, cooldown, or suppressed) is consumed. It does not retry on the next tick.
- shots_in_flight is combinational from registered shot_active.

## Timing

- RESET (sync) forces the following next cycle:
  - shot_active = 0, shot_dir = 0, shot_x = 0, shot_y = 0
  - shot_fired = 0, cooldown = 0, shoot_prev = 0
  - frame_clk_delayed = 0, tick = 0
- If the key is held through reset, the first tick after reset fires.
- RESET mid-flight kills all shots immediately and drops any pending tick.
- tick is asserted 1 Clk after frame_clk is first sampled high.
- Slot outputs and shot_fired update in the Clk after tick (registered, 1-cycle latency). shot_fired is high for exactly that one cycle.
- Latency from shot_clear to shot_active low is 1 Clk.

## Test plan

- Spawn right: RESET, then Megaman at (100,337), last_horizontal=1, key rises before tick. Expect slot0 active at (160,365), dir=1, shot_fired one pulse. After 3 more ticks, x = 172.
- Hold and cooldown: key held 20 ticks. Expect exactly one shot. Release, then press again 3 ticks after the spawn: no spawn. Press again after tick 8: slot1 spawns.
- Pool full: COOLDOWN_FRAMES=0, three presses with Megaman at x=100. Expect slots 0,1,2 filled in order, shots_in_flight=3. A 4th press gives no shot_fired and no state change.
- Edge retire: right shot at x=624, SHOT_SPEED=4. Next tick x=628; the tick after deactivates (632 > 631). Left spawn with Megaman_x=5 is suppressed, with no cooldown load.
- Clear vs tick: assert shot_clear[1] in the same cycle as tick while slot1 is live and a press occurs with slots 0 and 2 busy. Expect slot1 inactive and no spawn. The next press reuses slot1.
- Reset mid-flight: three live shots, RESET for 1 cycle. Expect all outputs at 0 the next cycle.
